// File: rtl/bram_fifo_pkg.sv
// Shared encodings, widths and helpers for FIFOs mapped onto one TDP36K half in SDP mode.
package bram_fifo_pkg;

  typedef enum logic [2:0] {
    MODE_1  = 3'd0,
    MODE_2  = 3'd1,
    MODE_4  = 3'd2,
    MODE_9  = 3'd3,
    MODE_18 = 3'd4,
    MODE_36 = 3'd5
  } bram_mode_e;

  localparam int MAX_ADDR_WIDTH = 14;

  typedef logic [MAX_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [MAX_ADDR_WIDTH:0]   cnt_t;
  typedef logic [MAX_ADDR_WIDTH+1:0] occ_t;

  // Address bits available in an 18K half for a given port width.
  function automatic int depth_for_dbits(input int dbits);
    case (dbits)
      1:       return 14;
      2:       return 13;
      4:       return 12;
      8, 9:    return 11;
      16, 18:  return 10;
      default: return 9;
    endcase
  endfunction

  function automatic bram_mode_e mode_for_dbits(input int dbits);
    case (dbits)
      1:       return MODE_1;
      2:       return MODE_2;
      4:       return MODE_4;
      8, 9:    return MODE_9;
      16, 18:  return MODE_18;
      default: return MODE_36;
    endcase
  endfunction

endpackage

// File: rtl/bram_fifo_out_stage.sv
// Two-entry skid that captures 1-cycle-latency BRAM read data and presents it
// as a first-word-fall-through valid/ready stream.
module bram_fifo_out_stage
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  pop_o,
  output logic [1:0]            occ_o
);

  logic                  inflight_q, inflight_d;
  logic                  head_valid_q, head_valid_d;
  logic                  spare_valid_q, spare_valid_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [DATA_WIDTH-1:0] spare_data_q, spare_data_d;

  assign pop_o   = head_valid_q && rready_i;
  assign valid_o = head_valid_q;
  assign data_o  = head_data_q;
  assign occ_o   = {1'b0, inflight_q} + {1'b0, head_valid_q} + {1'b0, spare_valid_q};

  // The spare is always older than returning data, so it refills the head first.
  always_comb begin
    inflight_d    = issue_i;
    head_valid_d  = head_valid_q;
    head_data_d   = head_data_q;
    spare_valid_d = spare_valid_q;
    spare_data_d  = spare_data_q;

    if (pop_o) begin
      head_valid_d  = spare_valid_q;
      spare_valid_d = 1'b0;
      if (spare_valid_q) begin
        head_data_d = spare_data_q;
      end
    end

    if (inflight_q) begin
      if (!head_valid_d) begin
        head_valid_d = 1'b1;
        head_data_d  = rdata_i;
      end else begin
        spare_valid_d = 1'b1;
        spare_data_d  = rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      head_valid_q  <= 1'b0;
      spare_valid_q <= 1'b0;
      head_data_q   <= '0;
      spare_data_q  <= '0;
    end else begin
      inflight_q    <= inflight_d;
      head_valid_q  <= head_valid_d;
      spare_valid_q <= spare_valid_d;
      head_data_q   <= head_data_d;
      spare_data_q  <= spare_data_d;
    end
  end

  a_occ_bounded: assert property (@(posedge clk) disable iff (rst) occ_o <= 2'd2);

endmodule

// File: rtl/bram_sdp_fifo_ctrl.sv
// Synchronous FIFO controller driving an SDP BRAM write port (B) and read port (A),
// with a first-word-fall-through output stream.
module bram_sdp_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 18,
  parameter int ADDR_WIDTH    = depth_for_dbits(DATA_WIDTH),
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  WR_EN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  output logic                  FULL_o,
  output logic                  ALMOST_FULL_o,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  input  logic                  RREADY_i,
  output logic                  EMPTY_o,
  output logic                  ALMOST_EMPTY_o,
  output logic [ADDR_WIDTH+1:0] COUNT_o,
  output logic                  OVERFLOW_o,
  output logic                  UNDERFLOW_o,
  output logic [ADDR_WIDTH-1:0] BRAM_WADDR_o,
  output logic [DATA_WIDTH-1:0] BRAM_WDATA_o,
  output logic                  BRAM_WEN_o,
  output logic [1:0]            BRAM_WBE_o,
  output logic [ADDR_WIDTH-1:0] BRAM_RADDR_o,
  output logic                  BRAM_REN_o,
  input  logic [DATA_WIDTH-1:0] BRAM_RDATA_i
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH+1:0] AEMPTY_CNT = (ADDR_WIDTH+2)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   bram_cnt_q, bram_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic       wen;
  logic       ren;
  logic       pop;
  logic [1:0] skid_occ;

  assign FULL_o        = (bram_cnt_q == FULL_CNT);
  assign ALMOST_FULL_o = (bram_cnt_q >= AFULL_CNT);
  assign wen           = WR_EN_i && !FULL_o;

  // Keep at most two words between the skid and the read pipe; a pop frees one slot.
  assign ren = (bram_cnt_q != '0) &&
               ((skid_occ < 2'd2) || ((skid_occ == 2'd2) && pop));

  assign BRAM_WADDR_o = wptr_q;
  assign BRAM_WDATA_o = WDATA_i;
  assign BRAM_WEN_o   = wen;
  assign BRAM_WBE_o   = {wen, wen};
  assign BRAM_RADDR_o = rptr_q;
  assign BRAM_REN_o   = ren;

  assign EMPTY_o        = !RVALID_o;
  assign COUNT_o        = {1'b0, bram_cnt_q} + {{ADDR_WIDTH{1'b0}}, skid_occ};
  assign ALMOST_EMPTY_o = (COUNT_o <= AEMPTY_CNT);
  assign OVERFLOW_o     = overflow_q;
  assign UNDERFLOW_o    = underflow_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    bram_cnt_d  = bram_cnt_q;
    overflow_d  = overflow_q || (WR_EN_i && FULL_o);
    underflow_d = underflow_q || (RREADY_i && !RVALID_o);

    if (wen) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (ren) begin
      rptr_d = rptr_q + 1'b1;
    end

    case ({wen, ren})
      2'b10:   bram_cnt_d = bram_cnt_q + 1'b1;
      2'b01:   bram_cnt_d = bram_cnt_q - 1'b1;
      default: bram_cnt_d = bram_cnt_q;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      bram_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      bram_cnt_q  <= bram_cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  bram_fifo_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk      (CLK_i),
    .rst      (RST_i),
    .issue_i  (ren),
    .rdata_i  (BRAM_RDATA_i),
    .rready_i (RREADY_i),
    .data_o   (RDATA_o),
    .valid_o  (RVALID_o),
    .pop_o    (pop),
    .occ_o    (skid_occ)
  );

  a_cnt_bounded: assert property (@(posedge CLK_i) disable iff (RST_i) bram_cnt_q <= FULL_CNT);

endmodule

// File: tb/tb_bram_sdp_fifo_ctrl.sv
// Directed bench for bram_sdp_fifo_ctrl with a behavioural 1-cycle-latency SDP BRAM.
module tb_bram_sdp_fifo_ctrl;

  localparam int DW    = 18;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rready = 1'b0;
  logic          full, almost_full, rvalid, empty, almost_empty, overflow, underflow;
  logic [DW-1:0] rdata;
  logic [AW+1:0] count;
  logic [AW-1:0] bram_waddr, bram_raddr;
  logic [DW-1:0] bram_wdata, bram_rdata;
  logic          bram_wen, bram_ren;
  logic [1:0]    bram_wbe;

  logic [DW-1:0] ram [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_wen) ram[bram_waddr] <= bram_wdata;
    if (bram_ren) bram_rdata <= ram[bram_raddr];
  end

  bram_sdp_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .CLK_i(clk), .RST_i(rst), .WR_EN_i(wr_en), .WDATA_i(wdata),
    .FULL_o(full), .ALMOST_FULL_o(almost_full), .RDATA_o(rdata), .RVALID_o(rvalid),
    .RREADY_i(rready), .EMPTY_o(empty), .ALMOST_EMPTY_o(almost_empty), .COUNT_o(count),
    .OVERFLOW_o(overflow), .UNDERFLOW_o(underflow),
    .BRAM_WADDR_o(bram_waddr), .BRAM_WDATA_o(bram_wdata), .BRAM_WEN_o(bram_wen),
    .BRAM_WBE_o(bram_wbe), .BRAM_RADDR_o(bram_raddr), .BRAM_REN_o(bram_ren),
    .BRAM_RDATA_i(bram_rdata)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; wr_en = 1'b0; rready = 1'b0; wdata = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if ({full, rvalid, empty, almost_empty, bram_wen, bram_ren, overflow, underflow} !== 8'b0011_0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 00110000",
               {full, rvalid, empty, almost_empty, bram_wen, bram_ren, overflow, underflow});
    end
    checks++;
    if (count !== 6'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (rdata !== 18'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    next_cycle();
  endtask

  task automatic test_single_push;
    wr_en = 1'b1; wdata = 18'h2A5A5;
    @(negedge clk);
    checks++;
    if ({bram_wen, bram_wbe} !== 3'b111) begin errors++; $display("[TB] FAIL sp_wen_wbe: got %b want 111", {bram_wen, bram_wbe}); end
    checks++;
    if (bram_waddr !== 4'd0) begin errors++; $display("[TB] FAIL sp_waddr: got %0d want 0", bram_waddr); end
    checks++;
    if (bram_ren !== 1'b0) begin errors++; $display("[TB] FAIL sp_ren_c0: got %b want 0", bram_ren); end
    next_cycle();
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bram_ren !== 1'b1 || bram_raddr !== 4'd0) begin
      errors++; $display("[TB] FAIL sp_ren_c1: got ren=%b raddr=%0d want ren=1 raddr=0", bram_ren, bram_raddr);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL sp_rvalid_c2: got %b want 0", rvalid); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 18'h2A5A5) begin
      errors++; $display("[TB] FAIL sp_data_c3: got valid=%b data=%h want valid=1 data=2a5a5", rvalid, rdata);
    end
    checks++;
    if (count !== 6'd1 || almost_empty !== 1'b1) begin
      errors++; $display("[TB] FAIL sp_count_c3: got count=%0d aempty=%b want 1/1", count, almost_empty);
    end
    next_cycle();
    rready = 1'b1;
    @(negedge clk);
    next_cycle();
    rready = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || count !== 6'd0) begin
      errors++; $display("[TB] FAIL sp_popped: got valid=%b count=%0d want 0/0", rvalid, count);
    end
    next_cycle();
  endtask

  task automatic test_fill_overflow;
    for (int c = 0; c <= 18; c++) begin
      wr_en = 1'b1; wdata = DW'(c);
      @(negedge clk);
      checks++;
      if (almost_full !== (c >= 14)) begin errors++; $display("[TB] FAIL fill_afull c=%0d: got %b want %b", c, almost_full, c >= 14); end
      checks++;
      if (full !== (c == 18)) begin errors++; $display("[TB] FAIL fill_full c=%0d: got %b want %b", c, full, c == 18); end
      checks++;
      if (bram_wen !== (c < 18)) begin errors++; $display("[TB] FAIL fill_wen c=%0d: got %b want %b", c, bram_wen, c < 18); end
      checks++;
      if (count !== 6'(c)) begin errors++; $display("[TB] FAIL fill_count c=%0d: got %0d want %0d", c, count, c); end
      if (c == 18) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf_early: got %b want 0", overflow); end
      end
      next_cycle();
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1 || count !== 6'd18) begin
      errors++; $display("[TB] FAIL ovf_state: got ovf=%b full=%b count=%0d want 1/1/18", overflow, full, count);
    end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 18'd0) begin errors++; $display("[TB] FAIL ovf_head: got valid=%b data=%h want 1/0", rvalid, rdata); end
    next_cycle();
  endtask

  task automatic test_drain_underflow;
    rready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== DW'(i)) begin
        errors++; $display("[TB] FAIL drain_word %0d: got valid=%b data=%h want 1/%h", i, rvalid, rdata, DW'(i));
      end
      checks++;
      if (count !== 6'(18 - i)) begin errors++; $display("[TB] FAIL drain_count %0d: got %0d want %0d", i, count, 18 - i); end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({rvalid, empty, underflow} !== 3'b010 || count !== 6'd0) begin
      errors++; $display("[TB] FAIL drain_empty: got valid=%b empty=%b udf=%b count=%0d want 0/1/0/0",
                         rvalid, empty, underflow, count);
    end
    next_cycle();
    rready = 1'b0;
    @(negedge clk);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_set: got %b want 1", underflow); end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    int got = 0;
    int drops = 0;
    bit started = 1'b0;
    rready = 1'b1;
    for (int c = 0; c < 80 && got < 40; c++) begin
      if (c < 40) begin wr_en = 1'b1; wdata = DW'(256 + c); end
      else wr_en = 1'b0;
      @(negedge clk);
      if (rvalid) begin
        started = 1'b1;
        checks++;
        if (rdata !== DW'(256 + got)) begin errors++; $display("[TB] FAIL b2b_word %0d: got %h want %h", got, rdata, DW'(256 + got)); end
        got++;
      end else if (started) begin
        drops++;
      end
      next_cycle();
    end
    wr_en = 1'b0; rready = 1'b0;
    checks++;
    if (got !== 40) begin errors++; $display("[TB] FAIL b2b_total: got %0d want 40", got); end
    checks++;
    if (drops !== 0) begin errors++; $display("[TB] FAIL b2b_gaps: got %0d want 0", drops); end
  endtask

  task automatic test_random_ready;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] expv;
    int pushed = 0;
    int popped = 0;
    do_reset();
    for (int c = 0; c < 600 && (pushed < 80 || sb.size() > 0); c++) begin
      wr_en = (pushed < 80) && !full;
      if (wr_en) begin
        wdata = DW'(18'h2000 + pushed * 7);
        sb.push_back(wdata);
        pushed++;
      end
      rready = (pushed < 80) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rvalid && rready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL rnd_extra: got %h with empty scoreboard", rdata);
        end else begin
          expv = sb.pop_front();
          if (rdata !== expv) begin errors++; $display("[TB] FAIL rnd_word %0d: got %h want %h", popped, rdata, expv); end
        end
        popped++;
      end
      next_cycle();
    end
    wr_en = 1'b0; rready = 1'b0;
    checks++;
    if (popped !== 80) begin errors++; $display("[TB] FAIL rnd_total: got %0d want 80", popped); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rnd_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_reset_midburst;
    do_reset();
    wr_en = 1'b1; wdata = 18'h0AAAA; rready = 1'b1;
    next_cycle();
    wdata = 18'h0BBBB; rready = 1'b0;
    @(negedge clk);
    checks++;
    if (underflow !== 1'b1 || bram_ren !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_pre: got udf=%b ren=%b want 1/1", underflow, bram_ren);
    end
    next_cycle();
    wdata = 18'h0CCCC; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== 6'd2) begin errors++; $display("[TB] FAIL mid_inflight_count: got %0d want 2", count); end
    next_cycle();
    rst = 1'b0; wr_en = 1'b1; wdata = 18'h00111;
    @(negedge clk);
    checks++;
    if ({rvalid, empty, full, overflow, underflow, bram_ren} !== 6'b010000) begin
      errors++; $display("[TB] FAIL mid_flags: got %b want 010000", {rvalid, empty, full, overflow, underflow, bram_ren});
    end
    checks++;
    if (count !== 6'd0 || bram_waddr !== 4'd0) begin
      errors++; $display("[TB] FAIL mid_count: got count=%0d waddr=%0d want 0/0", count, bram_waddr);
    end
    next_cycle();
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bram_ren !== 1'b1 || bram_raddr !== 4'd0) begin
      errors++; $display("[TB] FAIL mid_reissue: got ren=%b raddr=%0d want 1/0", bram_ren, bram_raddr);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 18'h00111) begin
      errors++; $display("[TB] FAIL mid_readback: got valid=%b data=%h want 1/00111", rvalid, rdata);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_drain_underflow();
    test_back_to_back();
    test_random_ready();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
